fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches into a one-cycle-latency
// instruction memory and buffers {pc, instr} pairs in a small FIFO for the decoder.
module fetch_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [DATA_WIDTH-1:0] fetch_pc_reg;
   logic [DATA_WIDTH-1:0] inflight_pc_reg;
   logic                  inflight_reg;
   logic [PTR_W-1:0]      head_reg;
   logic [PTR_W-1:0]      tail_reg;
   logic [CNT_W-1:0]      count_reg;

   logic [DATA_WIDTH-1:0] fifo_pc    [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_instr [DEPTH];

   logic                  pop;
   logic                  push;
   logic [OCC_W-1:0]      occupancy;

   assign out_valid = (count_reg != '0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_reg & ~redirect_valid;

   // Entries held plus the one still in flight, crediting a pop this cycle so a
   // full queue being drained keeps fetching back to back.
   assign occupancy = OCC_W'(count_reg) + OCC_W'(inflight_reg) - OCC_W'(pop);
   assign imem_req  = rst & ~redirect_valid & (occupancy < OCC_W'(DEPTH));
   assign imem_addr = fetch_pc_reg;

   assign out_pc    = fifo_pc[head_reg];
   assign out_instr = fifo_instr[head_reg];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_reg    <= RESET_PC;
         inflight_pc_reg <= '0;
         inflight_reg    <= 1'b0;
         head_reg        <= '0;
         tail_reg        <= '0;
         count_reg       <= '0;
      end else if (redirect_valid) begin
         // Flush everything; the response of any outstanding fetch is dropped.
         fetch_pc_reg <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
         inflight_reg <= 1'b0;
         head_reg     <= tail_reg;
         count_reg    <= '0;
      end else begin
         if (imem_req) begin
            fetch_pc_reg    <= fetch_pc_reg + DATA_WIDTH'(4);
            inflight_pc_reg <= fetch_pc_reg;
            inflight_reg    <= 1'b1;
         end else begin
            inflight_reg <= 1'b0;
         end
         if (push) tail_reg <= tail_reg + PTR_W'(1);
         if (pop)  head_reg <= head_reg + PTR_W'(1);
         if (push && !pop)
            count_reg <= count_reg + CNT_W'(1);
         else if (pop && !push)
            count_reg <= count_reg - CNT_W'(1);
      end
   end

   // Payload storage carries no reset; only the pointers and count qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[tail_reg]    <= inflight_pc_reg;
         fifo_instr[tail_reg] <= imem_rdata;
      end
   end

endmodule
